// File: rtl/fifo_stream_reader.sv
// ---------------------------------------------------------------------------
// fifo_stream_reader
//
// Consumer-side engine for the 512x60 FIFO (fifo_512_60bit). It issues FIFO
// pops, absorbs the one-cycle registered RAM read latency and re-presents the
// words as a valid/ready stream. A 2-entry skid buffer keeps the stream at one
// word per cycle while out_ready stays high. It also ensures that no word is
// lost or repeated under back-pressure.
//
// Optional feature (compile-time macro READER_LAST_EN):
//   defined   - a 16-bit burst counter drives out_last on every BURST_LEN-th
//               accepted word.
//   undefined - no counter; out_last is tied to 0.
//
// Parameters:
//   DW         data width; must match the attached FIFO's data width
//   BURST_LEN  words per burst for out_last (1..65535)
//
// Ports:
//   clk         clock
//   rst         synchronous active-high reset
//   clr         synchronous flush; assert together with the FIFO's clr
//   en          read enable; when low no new pops are issued, buffered words
//               still drain
//   fifo_empty  FIFO empty flag (combinational in the FIFO)
//   fifo_dout   FIFO read data, valid the cycle after fifo_re
//   fifo_re     FIFO pop strobe
//   out_valid   stream word valid
//   out_data    stream word
//   out_ready   downstream accept
//   out_last    last word of a burst (0 unless READER_LAST_EN)
//   busy        a word is in flight or buffered
// ---------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int DW        = 60,
    parameter int BURST_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dout,
    output logic          fifo_re,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          out_last,
    output logic          busy
);

    // Reject an out-of-range burst length at elaboration.
    if ((BURST_LEN < 1) || (BURST_LEN > 65535)) begin : g_bad_burst_len
        $error("fifo_stream_reader: BURST_LEN out of range");
    end

    // Registered state
    logic [1:0]    occ_r;           // skid buffer occupancy (0..2)
    logic          infl_r;          // a pop was issued last cycle
    logic          head_r;          // read pointer into the buffer
    logic          tail_r;          // write pointer into the buffer
    logic [DW-1:0] mem_r [2];       // skid buffer storage
    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic          out_last_r;
    logic          busy_r;

    // Next-state / combinational terms
    logic          pop_s;           // downstream handshake this cycle
    logic          cap_s;           // fifo_dout is captured this cycle
    logic [2:0]    level_s;         // occupancy after this cycle's pop
    logic          re_s;
    logic [1:0]    occ_next_s;
    logic          head_next_s;
    logic          tail_next_s;
    logic [DW-1:0] mem_next_s [2];
    logic [DW-1:0] data_next_s;
    logic          last_next_s;

    // Pop decision, buffer bookkeeping and the next head word.
    always_comb begin
        pop_s   = out_valid_r & out_ready;
        cap_s   = infl_r;
        // occ + infl never exceeds 2, and pop implies occ >= 1, so this
        // cannot underflow.
        level_s = {1'b0, occ_r} + {2'b00, infl_r} - {2'b00, pop_s};
        // Popping only when fewer than 2 words will be held guarantees the
        // returning word always has a free slot next cycle.
        re_s    = en & ~fifo_empty & ~rst & ~clr & (level_s < 3'd2);

        case ({cap_s, pop_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;  // idle, or capture and pop together
        endcase

        head_next_s = head_r ^ pop_s;
        tail_next_s = tail_r ^ cap_s;

        mem_next_s = mem_r;
        if (cap_s) begin
            mem_next_s[tail_r] = fifo_dout;
        end else begin
            mem_next_s[tail_r] = mem_r[tail_r];
        end

        // The output register follows the head entry. While stalled, head
        // and that entry are unchanged, so out_data holds.
        data_next_s = mem_next_s[head_next_s];
    end

`ifdef READER_LAST_EN
    localparam logic [15:0] LAST_CNT = 16'(BURST_LEN - 1);

    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;

    // Burst counter advances on each accepted word and wraps on the last one.
    always_comb begin
        if (pop_s) begin
            if (cnt_r == LAST_CNT) begin
                cnt_next_s = 16'd0;
            end else begin
                cnt_next_s = cnt_r + 16'd1;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
        // The counter equals the index of the word at the head, so out_last
        // marks the head word and stays put while it is stalled.
        last_next_s = (occ_next_s != 2'd0) && (cnt_next_s == LAST_CNT);
    end

    // Burst counter register.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_r <= 16'd0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end
`else
    assign last_next_s = 1'b0;
`endif

    // Skid buffer, in-flight flag and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_r       <= 2'd0;
            infl_r      <= 1'b0;
            head_r      <= 1'b0;
            tail_r      <= 1'b0;
            mem_r[0]    <= {DW{1'b0}};
            mem_r[1]    <= {DW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DW{1'b0}};
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else if (clr) begin
            // A word returning on fifo_dout now is dropped because infl is
            // cleared and no new pop is issued in this cycle.
            occ_r       <= 2'd0;
            infl_r      <= 1'b0;
            head_r      <= 1'b0;
            tail_r      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            occ_r       <= occ_next_s;
            infl_r      <= re_s;
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            mem_r       <= mem_next_s;
            out_valid_r <= (occ_next_s != 2'd0);
            out_data_r  <= data_next_s;
            out_last_r  <= last_next_s;
            busy_r      <= (occ_next_s != 2'd0) | re_s;
        end
    end

    assign fifo_re   = re_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int DW = 60;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_re;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    fifo_stream_reader #(.DW(DW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_re    (fifo_re),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cnt = 0;                // words accepted since last clr/rst

    logic [DW-1:0] fq[$];           // FIFO contents model
    logic [DW-1:0] exp_q[$];        // words popped from the FIFO, not yet accepted

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty = 1'b0;
    endtask

    // One clock cycle: called 1 time unit after a rising edge with inputs set.
    task automatic step(output logic re_seen);
        logic flush;
        logic [DW-1:0] w;
        #8;
        re_seen = fifo_re;
        flush   = rst | clr;
        chk("re_when_empty", {63'd0, fifo_re & fifo_empty}, 64'd0);
        chk("re_in_rst_clr", {63'd0, fifo_re & flush}, 64'd0);
        @(posedge clk);
        #1;
        if (flush) begin
            exp_q.delete();
            acc_cnt = 0;
        end
        if (clr) fq.delete();
        if (re_seen && fq.size() > 0) begin
            w = fq.pop_front();
            fifo_dout = w;
            exp_q.push_back(w);
        end else begin
            fifo_dout = 60'({$urandom(), $urandom()});
        end
        fifo_empty = (fq.size() == 0);
        cyc++;
    endtask

    task automatic drain(input int max_cyc);
        logic r;
        bit done;
        done = 1'b0;
        en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (exp_q.size() == 0 && fq.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
            step(r);
        end
        chk("drain_done", {63'd0, done}, 64'd1);
    endtask

    // Scoreboard monitor: samples 2 time units before each rising edge.
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    initial begin
        logic [DW-1:0] e;
        logic exp_last;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (exp_q.size() > 2) begin
                    chk("held_words_le2", 64'(exp_q.size()), 64'd2);
                end
                if (stall_prev && out_valid) begin
                    chk("stall_stable", 64'(out_data), 64'(prev_data));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 64'(out_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
`ifdef READER_LAST_EN
                        exp_last = ((acc_cnt % BL) == (BL - 1));
`else
                        exp_last = 1'b0;
`endif
                        chk("stream_data", 64'(out_data), 64'(e));
                        chk("out_last", {63'd0, out_last}, {63'd0, exp_last});
                        acc_cnt++;
                    end
                end
            end
            stall_prev = out_valid & ~out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        logic r;
        int re_cyc, re_cnt, re_first, re_last, v_cnt, v_first, v_last, busy_low, consec;
        bit found, vprev;
        int pat [5];
        pat = '{1, 0, 0, 1, 0};

        rst = 1'b1; clr = 1'b0; en = 1'b1; out_ready = 1'b1;
        fifo_dout = {DW{1'b0}}; fifo_empty = 1'b1;
        @(posedge clk);
        #1;

        // Reset with a non-empty FIFO: nothing moves.
        for (int i = 0; i < 5; i++) push_word(60'(32'h100 + i));
        for (int i = 0; i < 3; i++) begin
            step(r);
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_out_last", {63'd0, out_last}, 64'd0);
        end
        rst = 1'b0;

        // First-word latency: out_valid two cycles after fifo_re rises.
        re_cyc = -1; found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(r);
            if (r && re_cyc < 0) re_cyc = cyc - 1;
            if (out_valid && re_cyc >= 0) begin
                chk("first_latency", 64'(cyc - re_cyc), 64'd2);
                found = 1'b1;
                break;
            end
        end
        chk("first_word_seen", {63'd0, found}, 64'd1);
        drain(60);

        // Streaming 20 words with out_ready high.
        for (int i = 1; i <= 20; i++) push_word(60'(i));
        re_cnt = 0; re_first = -1; re_last = -1;
        v_cnt = 0; v_first = -1; v_last = -1; busy_low = -1;
        for (int i = 0; i < 40; i++) begin
            step(r);
            if (r) begin
                re_cnt++;
                if (re_first < 0) re_first = cyc - 1;
                re_last = cyc - 1;
            end
            if (out_valid) begin
                v_cnt++;
                if (v_first < 0) v_first = cyc;
                v_last = cyc;
            end
            if (re_cnt == 20 && !busy && busy_low < 0) busy_low = cyc;
        end
        chk("stream_re_count", 64'(re_cnt), 64'd20);
        chk("stream_re_span", 64'(re_last - re_first), 64'd19);
        chk("stream_valid_count", 64'(v_cnt), 64'd20);
        chk("stream_valid_span", 64'(v_last - v_first), 64'd19);
        chk("stream_busy_fall", 64'(busy_low - re_last), 64'd3);

        // Back-pressure with out_ready pattern 1,0,0,1,0.
        for (int i = 0; i < 10; i++) push_word(60'({$urandom(), $urandom()}));
        for (int i = 0; i < 50; i++) begin
            out_ready = (pat[i % 5] != 0);
            step(r);
        end
        drain(60);

        // Underflow: one word written every 4 cycles.
        out_ready = 1'b1;
        re_cnt = 0; v_cnt = 0; consec = 0; vprev = 1'b0;
        for (int w = 0; w < 10; w++) begin
            push_word(60'(32'hA000 + w));
            for (int k = 0; k < 4; k++) begin
                step(r);
                if (r) re_cnt++;
                if (out_valid) begin
                    v_cnt++;
                    if (vprev) consec++;
                end
                vprev = out_valid;
            end
        end
        chk("uf_re_count", 64'(re_cnt), 64'd10);
        chk("uf_valid_count", 64'(v_cnt), 64'd10);
        chk("uf_valid_pulse", 64'(consec), 64'd0);
        drain(20);

        // clr mid-stream while a word is in flight.
        for (int i = 0; i < 8; i++) push_word(60'(32'hC000 + i));
        for (int i = 0; i < 4; i++) step(r);
        clr = 1'b1; out_ready = 1'b0;
        step(r);
        clr = 1'b0;
        chk("clr_out_valid", {63'd0, out_valid}, 64'd0);
        chk("clr_busy", {63'd0, busy}, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(r);
            chk("clr_quiet_valid", {63'd0, out_valid}, 64'd0);
        end
        for (int i = 0; i < 5; i++) push_word(60'(32'hD000 + i));
        drain(40);

        // Reset mid-operation.
        for (int i = 0; i < 6; i++) push_word(60'(32'hE000 + i));
        for (int i = 0; i < 3; i++) step(r);
        rst = 1'b1;
        step(r);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        drain(60);

        // Random writes, random out_ready and en.
        begin
            int pushed;
            pushed = 0;
            for (int i = 0; i < 150; i++) begin
                if (pushed < 30 && $urandom_range(0, 2) == 0) begin
                    push_word(60'({$urandom(), $urandom()}));
                    pushed++;
                end
                out_ready = ($urandom_range(0, 1) == 1);
                en = ($urandom_range(0, 4) != 0);
                step(r);
            end
        end
        drain(100);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
